// File: rtl/alu_pkg.sv
// Shared opcode, state and iterative-mode definitions for the sequential ALU.
// Imported by alu_seq and alu_iter_unit.
package alu_pkg;

    localparam logic [3:0] OP_SLL   = 4'b0000;
    localparam logic [3:0] OP_SRL   = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_SLTU  = 4'b0110;
    localparam logic [3:0] OP_MUL   = 4'b0111;
    localparam logic [3:0] OP_MULHU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;
    localparam logic [3:0] OP_REMU  = 4'b1010;
    localparam logic [3:0] OP_SUB   = 4'b1011;
    localparam logic [3:0] OP_SRA   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b1101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_MULH = 2'd1,
        MODE_DIV  = 2'd2,
        MODE_REM  = 2'd3
    } iter_mode_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
    endfunction

    function automatic iter_mode_t iter_mode(input logic [3:0] op);
        case (op)
            OP_MULHU: return MODE_MULH;
            OP_DIVU:  return MODE_DIV;
            OP_REMU:  return MODE_REM;
            default:  return MODE_MUL;
        endcase
    endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Shared shift-add multiplier / restoring divider, one step per clock for WIDTH clocks.
// o_done and o_result are valid combinationally during the final step.
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  iter_mode_t       i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic             r_active;
    logic [CW-1:0]    r_count;
    iter_mode_t       r_mode;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH-1:0] w_diff;
    logic             w_fits;
    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;

    // Multiply: hi accumulates the partial product while the multiplier drains out of lo.
    assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);

    // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    // A zero divisor always "fits", which leaves all-ones quotient and remainder == dividend.
    assign w_shifted = {r_hi, r_lo[WIDTH-1]};
    assign w_fits    = (w_shifted >= {1'b0, r_b});
    assign w_diff    = w_shifted[WIDTH-1:0] - r_b;

    always_comb begin
        w_hi_next = r_hi;
        w_lo_next = r_lo;
        case (r_mode)
            MODE_MUL, MODE_MULH: begin
                {w_hi_next, w_lo_next} = {w_mul_sum, r_lo[WIDTH-1:1]};
            end
            default: begin
                if (w_fits) begin
                    w_hi_next = w_diff;
                    w_lo_next = {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    w_hi_next = w_shifted[WIDTH-1:0];
                    w_lo_next = {r_lo[WIDTH-2:0], 1'b0};
                end
            end
        endcase
    end

    assign o_done = r_active && (r_count == CW'(1));

    always_comb begin
        o_result = w_lo_next;
        if (r_mode == MODE_MULH || r_mode == MODE_REM) begin
            o_result = w_hi_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_active <= 1'b0;
            r_count  <= '0;
            r_mode   <= MODE_MUL;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_count  <= CW'(WIDTH);
            r_mode   <= i_mode;
            r_hi     <= '0;
            r_lo     <= i_a;
            r_b      <= i_b;
        end else if (r_active) begin
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/shift/add/compare ops, iterative mul/div via alu_iter_unit.
// One operation in flight; result and equal are held until the consumer takes them.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [3:0]       S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             equal,
    output logic             busy
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_result;
    logic             r_equal;

    logic             w_accept;
    logic             w_iter_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_result;
    logic [WIDTH-1:0] w_alu_result;
    logic [SHW-1:0]   w_shamt;
    logic signed [WIDTH-1:0] w_x_signed;

    assign w_shamt      = Y[SHW-1:0];
    assign w_x_signed   = X;
    assign w_accept     = in_valid && in_ready;
    assign w_iter_start = w_accept && is_iter(S);

    always_comb begin
        w_alu_result = '0;
        case (S)
            OP_SLL:  w_alu_result = X << w_shamt;
            OP_SRL:  w_alu_result = X >> w_shamt;
            OP_ADD:  w_alu_result = X + Y;
            OP_AND:  w_alu_result = X & Y;
            OP_OR:   w_alu_result = X | Y;
            OP_XOR:  w_alu_result = X ^ Y;
            OP_SLTU: w_alu_result = {{(WIDTH-1){1'b0}}, (X < Y)};
            OP_SUB:  w_alu_result = X - Y;
            OP_SRA:  w_alu_result = w_x_signed >>> w_shamt;
            OP_SLT:  w_alu_result = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
            default: w_alu_result = '0;
        endcase
    end

    alu_iter_unit #(
        .WIDTH(WIDTH)
    ) u_iter (
        .i_clk     (clk),
        .i_reset_n (reset),
        .i_start   (w_iter_start),
        .i_mode    (iter_mode(S)),
        .i_a       (X),
        .i_b       (Y),
        .o_done    (w_iter_done),
        .o_result  (w_iter_result)
    );

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = is_iter(S) ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (w_iter_done) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Single-cycle results land at the accept edge; iterative ones at the unit's final step.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_result <= '0;
            r_equal  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_equal <= (X == Y);
                if (!is_iter(S)) begin
                    r_result <= w_alu_result;
                end
            end
            if (r_state == ST_BUSY && w_iter_done) begin
                r_result <= w_iter_result;
            end
        end
    end

    assign result = r_result;
    assign equal  = r_equal;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32): directed cases, randomized ops against
// an arithmetic reference model, backpressure, reset abort and back-to-back throughput.
module tb_alu_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] X;
    logic [31:0] Y;
    logic [3:0]  S;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        equal;
    logic        busy;

    int nCompared;
    int nMismatched;

    alu_seq #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X         (X),
        .Y         (Y),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .equal     (equal),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model straight from the opcode table, using 64-bit arithmetic.
    function automatic logic [31:0] refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        int unsigned sh;
        prod = {32'd0, a} * {32'd0, b};
        sh   = b % 32;
        case (op)
            4'd0:  return a << sh;
            4'd1:  return a >> sh;
            4'd2:  return a + b;
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return (a < b) ? 32'd1 : 32'd0;
            4'd7:  return prod[31:0];
            4'd8:  return prod[63:32];
            4'd9:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10: return (b == 0) ? a : a % b;
            4'd11: return a - b;
            4'd12: return $unsigned($signed(a) >>> sh);
            4'd13: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int refLatency(input logic [3:0] op);
        return (op >= 4'd7 && op <= 4'd10) ? 33 : 1;
    endfunction

    // Drives one operation from IDLE and collects what the DUT shows; no checking here.
    task automatic driveOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] res, output logic eq, output int lat,
                           output int busyCycles, output int readyViolations, output logic timedOut);
        lat = 1;
        busyCycles = 0;
        readyViolations = 0;
        timedOut = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; X = a; Y = b; S = op; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; X = $urandom; Y = $urandom; S = 4'($urandom);
        while (!out_valid && lat < 100) begin
            if (busy) busyCycles++;
            if (in_ready) readyViolations++;
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end
        if (!out_valid) timedOut = 1'b1;
        res = result;
        eq = equal;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0; S = '0;
        repeat (3) @(posedge clk);
        #1;
        nCompared++;
        if ({in_ready, out_valid, busy, equal} !== 4'b1000 || result !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: got rdy/vld/busy/eq=%b result=%h, expected 1000 result=0",
                     {in_ready, out_valid, busy, equal}, result);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add_latency();
        logic [31:0] res; logic eq; int lat, bc, rv; logic to;
        driveOp(4'd2, 32'd5, 32'd7, res, eq, lat, bc, rv, to);
        nCompared++;
        if (to || res !== 32'd12 || eq !== 1'b0 || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL add_5_7: got result=%h eq=%b lat=%0d timeout=%b, expected 0000000c 0 1 0", res, eq, lat, to);
        end
        nCompared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL add_ready_back: got in_ready=%b out_valid=%b, expected 1 0", in_ready, out_valid);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        int          expLat;
        int          expBusy;
    } directed_t;

    task automatic test_directed();
        directed_t cases[$];
        logic [31:0] res; logic eq; int lat, bc, rv; logic to;
        cases.push_back('{4'd9,  32'd100,        32'd7,        32'd14,         33, 32});
        cases.push_back('{4'd10, 32'd100,        32'd7,        32'd2,          33, 32});
        cases.push_back('{4'd9,  32'h1234,       32'd0,        32'hFFFF_FFFF,  33, 32});
        cases.push_back('{4'd10, 32'h1234,       32'd0,        32'h1234,       33, 32});
        cases.push_back('{4'd8,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 32});
        cases.push_back('{4'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0001, 33, 32});
        cases.push_back('{4'd12, 32'h8000_0000,  32'h24,       32'hF800_0000,  1, 0});
        cases.push_back('{4'd13, 32'hFFFF_FFFF,  32'd1,        32'd1,          1, 0});
        cases.push_back('{4'd6,  32'hFFFF_FFFF,  32'd1,        32'd0,          1, 0});
        cases.push_back('{4'd14, 32'hDEAD_BEEF,  32'h1234,     32'd0,          1, 0});
        cases.push_back('{4'd15, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         1, 0});
        foreach (cases[i]) begin
            driveOp(cases[i].op, cases[i].a, cases[i].b, res, eq, lat, bc, rv, to);
            nCompared++;
            if (to || res !== cases[i].expRes || lat !== cases[i].expLat ||
                bc !== cases[i].expBusy || rv !== 0 || eq !== (cases[i].a == cases[i].b)) begin
                nMismatched++;
                $display("[TB] FAIL directed_%0d op=%h: got result=%h lat=%0d busy=%0d rdyViol=%0d eq=%b, expected %h %0d %0d 0 %b",
                         i, cases[i].op, res, lat, bc, rv, eq, cases[i].expRes, cases[i].expLat,
                         cases[i].expBusy, (cases[i].a == cases[i].b));
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, res; logic [3:0] op; logic eq; int lat, bc, rv; logic to;
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = ($urandom % 3 == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            b  = ($urandom % 4 == 0) ? a : (($urandom % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom);
            driveOp(op, a, b, res, eq, lat, bc, rv, to);
            nCompared++;
            if (to || res !== refModel(op, a, b) || eq !== (a == b) || lat !== refLatency(op)) begin
                nMismatched++;
                $display("[TB] FAIL random_%0d op=%h a=%h b=%h: got result=%h eq=%b lat=%0d, expected %h %b %0d",
                         i, op, a, b, res, eq, lat, refModel(op, a, b), (a == b), refLatency(op));
            end
        end
    endtask

    task automatic test_backpressure();
        int waitCycles;
        @(negedge clk);
        in_valid = 1'b1; X = 32'd3; Y = 32'd5; S = 4'd11; out_ready = 1'b0;
        @(posedge clk); #1;
        X = 32'd1; Y = 32'd1; S = 4'd2;
        waitCycles = 0;
        while (!out_valid && waitCycles < 50) begin
            @(posedge clk); #1;
            waitCycles++;
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            nCompared++;
            if (result !== 32'hFFFF_FFFE || out_valid !== 1'b1 || in_ready !== 1'b0 || equal !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL backpressure_hold_%0d: got result=%h vld=%b rdy=%b eq=%b, expected fffffffe 1 0 0",
                         c, result, out_valid, in_ready, equal);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nCompared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_release: got rdy=%b vld=%b, expected 1 0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        nCompared++;
        if (out_valid !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL backpressure_ignored_input: got out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_reset_abort();
        int spurious;
        logic [31:0] res; logic eq; int lat, bc, rv; logic to;
        @(negedge clk);
        in_valid = 1'b1; X = 32'd100; Y = 32'd100; S = 4'd9; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        nCompared++;
        if ({in_ready, out_valid, busy, equal} !== 4'b1000 || result !== 32'd0) begin
            nMismatched++;
            $display("[TB] FAIL reset_abort: got rdy/vld/busy/eq=%b result=%h, expected 1000 result=0",
                     {in_ready, out_valid, busy, equal}, result);
        end
        @(negedge clk);
        reset = 1'b1;
        spurious = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (out_valid || busy) spurious++;
        end
        out_ready = 1'b0;
        nCompared++;
        if (spurious !== 0) begin
            nMismatched++;
            $display("[TB] FAIL reset_abort_no_output: got %0d active cycles, expected 0", spurious);
        end
        driveOp(4'd2, 32'd5, 32'd7, res, eq, lat, bc, rv, to);
        nCompared++;
        if (to || res !== 32'd12 || lat !== 1) begin
            nMismatched++;
            $display("[TB] FAIL add_after_reset: got result=%h lat=%0d, expected 0000000c 1", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] expQ[$];
        logic [31:0] exp;
        int accepted;
        logic [3:0] singles[10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd11, 4'd12, 4'd13};
        accepted = 0;
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        S = singles[$urandom_range(0, 9)]; X = $urandom; Y = $urandom;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                exp = (expQ.size() > 0) ? expQ.pop_front() : 32'hx;
                nCompared++;
                if (result !== exp) begin
                    nMismatched++;
                    $display("[TB] FAIL back_to_back_result_%0d: got %h, expected %h", c, result, exp);
                end
            end
            if (in_valid && in_ready) begin
                expQ.push_back(refModel(S, X, Y));
                accepted++;
            end
            @(posedge clk); #1;
            if (in_ready) begin
                S = singles[$urandom_range(0, 9)]; X = $urandom; Y = $urandom;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        nCompared++;
        if (accepted !== 20) begin
            nMismatched++;
            $display("[TB] FAIL back_to_back_throughput: got %0d accepts in 40 cycles, expected 20", accepted);
        end
    endtask

    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_add_latency();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle RISC-V datapath ALU.
- Logic, shift, add and compare operations complete in one cycle.
- Multiply, multiply-high, divide and remainder run iteratively over WIDTH cycles, so no wide combinational multiplier or divider is built.
- Sits between the decode/operand stage and writeback, and stalls the pipeline through valid/ready.

Parameters:
WIDTH, 32, operand/result width in bits; must be a power of two, >= 8
SHW, $clog2(WIDTH), shift-amount bits taken from Y[SHW-1:0]

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
in_valid  input  1  operands and opcode valid
in_ready  output  1  block can accept an operation
X  input  WIDTH  operand A
Y  input  WIDTH  operand B / shift amount
S  input  4  opcode
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  operation result
equal  output  1  registered (X == Y) of the accepted operands
busy  output  1  iterative operation in progress

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, equal=0.
  - Any in-flight operation is discarded.
- Opcodes:
  - 0000 SLL X<<Y[SHW-1:0]
  - 0001 SRL logical right shift
  - 0010 ADD X+Y, mod 2^WIDTH
  - 0011 AND
  - 0100 OR
  - 0101 XOR
  - 0110 SLTU unsigned X<Y, zero-extended
  - 0111 MUL, low WIDTH bits of the unsigned product
  - 1000 MULHU, high WIDTH bits of the unsigned 2*WIDTH-bit product
  - 1001 DIVU
  - 1010 REMU
  - 1011 SUB X-Y, mod 2^WIDTH
  - 1100 SRA arithmetic right shift
  - 1101 SLT signed X<Y
  - 1110, 1111: result=0, single-cycle, no error flag.
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. Handshake = in_valid&&in_ready at an edge; it latches X, Y, S and equal.
    - Single-cycle op -> DONE; result available the next cycle (latency 1).
    - Opcodes 0111-1010 -> BUSY; counter loaded with WIDTH.
  - BUSY: in_ready=0, busy=1.
    - MUL/MULHU: one shift-add step per cycle.
    - DIVU/REMU: one restoring shift-subtract step per cycle.
    - Counter decrements each cycle; when it reaches 0 the result is written and the state moves to DONE.
    - Accept-to-out_valid latency is exactly WIDTH+1 cycles.
  - DONE: out_valid=1, in_ready=0.
    - result and equal are held stable until out_valid&&out_ready at an edge, then -> IDLE.
    - No same-cycle accept of a new operation: maximum throughput is one op every 2 cycles.
- Divide by zero (Y==0): DIVU -> all ones; REMU -> X. Still takes WIDTH+1 cycles, with no early exit.
- Overflow/carry: not reported; ADD, SUB and MUL wrap.
- Inputs are ignored while in_ready=0. X, Y and S may change freely after the handshake.
- Reset in BUSY or DONE aborts the operation; out_valid never pulses for it.
- Reset has priority over every handshake in the same cycle.

Decomposition:
- alu_pkg holds:
  - opcode localparams (OP_SLL … OP_SLT)
  - state encoding (ST_IDLE/ST_BUSY/ST_DONE)
  - function is_iter(op)
- Sub-module alu_iter_unit contains the shared shift-add/shift-subtract datapath:
  - 2*WIDTH accumulator, counter and start/done pulse
  - modes mul, mulh, div, rem
  - it is reused by a future signed M-extension variant.
- The top holds the FSM, handshake and single-cycle ops.

Test Plan:
- ADD X=5, Y=7 accepted at cycle 0, out_ready=1 -> out_valid at cycle 1, result=12, equal=0; in_ready back to 1 at cycle 2.
- DIVU X=100, Y=7 (WIDTH=32) -> busy for 32 cycles, out_valid at cycle 33, result=14. REMU with the same operands -> result=2.
- DIVU X=0x1234, Y=0 -> result=0xFFFFFFFF. REMU X=0x1234, Y=0 -> result=0x1234. Both take 33 cycles.
- MULHU X=Y=0xFFFFFFFF -> result=0xFFFFFFFE. MUL with the same operands -> result=0x00000001.
- SRA X=0x80000000, Y=0x24 (shift 4) -> result=0xF8000000. SLT X=0xFFFFFFFF, Y=1 -> result 1. SLTU with the same operands -> result 0.
- Backpressure and reset:
  - Hold out_ready=0 for 5 cycles after SUB 3-5 -> result=0xFFFFFFFE stays stable and in_ready=0 throughout.
  - Assert reset at cycle 10 of a DIVU -> next cycle state IDLE, out_valid=0, result=0; a following ADD completes normally.
